// File: rtl/mm_responder.sv
// mm_responder: main-memory side of the cache-miss interface.
// Serves one block per request (refill read or write-back) after a fixed
// latency, moving WORDS_PER_BLOCK word beats at one beat per cycle.
//
// Ports:
//   CLK, RESET         clock (rising edge), synchronous active-high reset
//   Access_MM          request level, sampled only while idle
//   MM_Write           1 = write-back, 0 = refill read (sampled with request)
//   MM_Addr            byte address anywhere inside the target block
//   MM_WData           write beat data, consumed while MM_WReady = 1
//   MM_RData           read beat data, zero unless MM_RValid = 1
//   MM_RValid          read beat valid
//   MM_WReady          write beat consumed this cycle
//   MM_Busy            transaction in progress
//   MM_Done            one-cycle completion pulse
module mm_responder #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Access_MM,
    input  logic              MM_Write,
    input  logic [ADDR_W-1:0] MM_Addr,
    input  logic [DATA_W-1:0] MM_WData,
    output logic [DATA_W-1:0] MM_RData,
    output logic              MM_RValid,
    output logic              MM_WReady,
    output logic              MM_Busy,
    output logic              MM_Done
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int BEAT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [IDX_W-1:0]  BLK_MASK  = ~(IDX_W'(WORDS_PER_BLOCK - 1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_wait;
    logic [CNT_W-1:0]   w_wait_nx;
    logic [BEAT_W-1:0]  r_beat;
    logic [BEAT_W-1:0]  w_beat_nx;
    logic [IDX_W-1:0]   r_base;
    logic [IDX_W-1:0]   w_base_nx;
    logic               r_write;
    logic               w_write_nx;

    logic [DATA_W-1:0]  r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_addr;
    logic               w_xfer;
    logic               w_unused_addr;

    // Truncating to IDX_W bits is the "mod DEPTH_WORDS" of the mapping.
    assign w_idx  = MM_Addr[IDX_W+1:2];
    assign w_addr = r_base + IDX_W'(r_beat);
    assign w_xfer = (r_state == S_XFER);

    assign w_unused_addr = ^{MM_Addr[ADDR_W-1:IDX_W+2], MM_Addr[1:0]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_beat  <= '0;
            r_base  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_wait  <= w_wait_nx;
            r_beat  <= w_beat_nx;
            r_base  <= w_base_nx;
            r_write <= w_write_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_wait_nx  = r_wait;
        w_beat_nx  = r_beat;
        w_base_nx  = r_base;
        w_write_nx = r_write;
        unique case (r_state)
            S_IDLE: begin
                if (Access_MM) begin
                    w_base_nx  = w_idx & BLK_MASK;
                    w_write_nx = MM_Write;
                    w_wait_nx  = WAIT_INIT;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_beat_nx  = '0;
                    w_state_nx = S_XFER;
                end else begin
                    w_wait_nx = r_wait - 1'b1;
                end
            end
            S_XFER: begin
                if (r_beat == LAST_BEAT) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_beat_nx = r_beat + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A reset landing on a write beat aborts that beat as well.
    always_ff @(posedge CLK) begin
        if (!RESET && w_xfer && r_write) begin
            r_mem[w_addr] <= MM_WData;
        end
    end

    assign MM_RValid = w_xfer && !r_write;
    assign MM_WReady = w_xfer && r_write;
    assign MM_Busy   = (r_state != S_IDLE);
    assign MM_Done   = (r_state == S_DONE);
    assign MM_RData  = MM_RValid ? r_mem[w_addr] : '0;

endmodule

// File: tb/tb_mm_responder.sv
// tb_mm_responder: directed bench for mm_responder.
// Cycle c counts from the edge that accepts the request (cycle 1 = first WAIT).
module tb_mm_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Access_MM = 1'b0;
    logic        MM_Write = 1'b0;
    logic [31:0] MM_Addr = '0;
    logic [31:0] MM_WData = '0;
    logic [31:0] MM_RData;
    logic        MM_RValid;
    logic        MM_WReady;
    logic        MM_Busy;
    logic        MM_Done;

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf [4];
    logic [3:0]  obs_f [1:10];
    logic [31:0] obs_d [1:10];

    mm_responder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Access_MM (Access_MM),
        .MM_Write  (MM_Write),
        .MM_Addr   (MM_Addr),
        .MM_WData  (MM_WData),
        .MM_RData  (MM_RData),
        .MM_RValid (MM_RValid),
        .MM_WReady (MM_WReady),
        .MM_Busy   (MM_Busy),
        .MM_Done   (MM_Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Flags are {Busy, RValid, WReady, Done} for a single isolated block.
    function automatic logic [3:0] exp_flags(int c, bit wr);
        bit xf;
        xf = (c >= 5) && (c <= 8);
        return {(c >= 1) && (c <= 9), xf && !wr, xf && wr, c == 9};
    endfunction

    // Drives one block and records outputs for cycles 1..10.
    task automatic run_block(input bit wr, input logic [31:0] addr,
                             input bit glitch);
        Access_MM = 1'b1;
        MM_Write  = wr;
        MM_Addr   = addr;
        MM_WData  = '0;
        tick();
        Access_MM = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (glitch && c == 2) begin
                Access_MM = 1'b1;
                MM_Write  = !wr;
                MM_Addr   = addr ^ 32'h80;
            end
            if (glitch && c == 4) Access_MM = 1'b0;
            MM_WData = (c >= 5 && c <= 8) ? wbuf[c-5] : 32'hBAD0_0000 + 32'(c);
            obs_f[c] = {MM_Busy, MM_RValid, MM_WReady, MM_Done};
            obs_d[c] = MM_RData;
            tick();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({MM_Busy, MM_RValid, MM_WReady, MM_Done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {MM_Busy, MM_RValid, MM_WReady, MM_Done});
        end
        checks++;
        if (MM_RData !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", MM_RData);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_write_then_read();
        logic [31:0] e [4];
        logic [31:0] ed;
        e = '{32'h11, 32'h22, 32'h33, 32'h44};
        wbuf = e;
        run_block(1'b1, 32'h40, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (obs_f[c] !== exp_flags(c, 1'b1)) begin
                failures++;
                $display("FAIL wb_flags cyc=%0d got=%b exp=%b",
                         c, obs_f[c], exp_flags(c, 1'b1));
            end
            checks++;
            if (obs_d[c] !== 32'h0) begin
                failures++;
                $display("FAIL wb_rdata cyc=%0d got=%h exp=0", c, obs_d[c]);
            end
        end
        run_block(1'b0, 32'h4C, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? e[c-5] : 32'h0;
            checks++;
            if (obs_f[c] !== exp_flags(c, 1'b0)) begin
                failures++;
                $display("FAIL rd_flags cyc=%0d got=%b exp=%b",
                         c, obs_f[c], exp_flags(c, 1'b0));
            end
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL rd_data cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
    endtask

    task automatic test_alignment();
        logic [31:0] e [4];
        logic [31:0] ed;
        e = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_block(1'b0, 32'h4A, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? e[c-5] : 32'h0;
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL align_data cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e [4];
        logic [31:0] ed;
        e = '{32'h55, 32'h66, 32'h77, 32'h88};
        wbuf = e;
        run_block(1'b1, 32'h1000, 1'b0);
        run_block(1'b0, 32'h0000, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? e[c-5] : 32'h0;
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL wrap_data cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1 [4];
        logic [31:0] e2 [4];
        logic [31:0] ed;
        logic [3:0]  ef;
        logic [3:0]  of;
        logic [31:0] od;
        bit          x1;
        bit          x2;
        e1 = '{32'h11, 32'h22, 32'h33, 32'h44};
        e2 = '{32'h55, 32'h66, 32'h77, 32'h88};
        Access_MM = 1'b1;
        MM_Write  = 1'b0;
        MM_Addr   = 32'h40;
        tick();
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) MM_Addr = 32'h0;
            if (c == 11) Access_MM = 1'b0;
            x1 = (c >= 5) && (c <= 8);
            x2 = (c >= 15) && (c <= 18);
            ef = {(c != 10) && (c <= 19), x1 || x2, 1'b0, (c == 9) || (c == 19)};
            ed = x1 ? e1[c-5] : (x2 ? e2[c-15] : 32'h0);
            of = {MM_Busy, MM_RValid, MM_WReady, MM_Done};
            od = MM_RData;
            checks++;
            if (of !== ef) begin
                failures++;
                $display("FAIL b2b_flags cyc=%0d got=%b exp=%b", c, of, ef);
            end
            checks++;
            if (od !== ed) begin
                failures++;
                $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, od, ed);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b [4];
        logic [31:0] e [4];
        logic [31:0] ed;
        b = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        e = '{32'hB0, 32'hB1, 32'hA2, 32'hA3};
        wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_block(1'b1, 32'h80, 1'b0);
        Access_MM = 1'b1;
        MM_Write  = 1'b1;
        MM_Addr   = 32'h80;
        tick();
        Access_MM = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            MM_WData = (c >= 5) ? b[c-5] : 32'h0;
            if (c == 7) begin
                checks++;
                if (MM_WReady !== 1'b1) begin
                    failures++;
                    $display("FAIL rstmid_wready got=%b exp=1", MM_WReady);
                end
                RESET = 1'b1;
            end
            tick();
        end
        RESET = 1'b0;
        checks++;
        if ({MM_Busy, MM_RValid, MM_WReady, MM_Done, MM_RData} !== 36'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b/%h exp=0000/0",
                     {MM_Busy, MM_RValid, MM_WReady, MM_Done}, MM_RData);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({MM_Busy, MM_Done} !== 2'b00) begin
                failures++;
                $display("FAIL rstmid_idle step=%0d got=%b exp=00",
                         c, {MM_Busy, MM_Done});
            end
        end
        run_block(1'b0, 32'h80, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? e[c-5] : 32'h0;
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL rstmid_data cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [31:0] e [4];
        logic [31:0] o [4];
        logic [31:0] ed;
        e = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        o = '{32'h11, 32'h22, 32'h33, 32'h44};
        wbuf = e;
        run_block(1'b1, 32'hC0, 1'b0);
        wbuf = '{32'hEE, 32'hEE, 32'hEE, 32'hEE};
        run_block(1'b0, 32'hC0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? e[c-5] : 32'h0;
            checks++;
            if (obs_f[c] !== exp_flags(c, 1'b0)) begin
                failures++;
                $display("FAIL ign_flags cyc=%0d got=%b exp=%b",
                         c, obs_f[c], exp_flags(c, 1'b0));
            end
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL ign_data cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
        run_block(1'b0, 32'h40, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            ed = (c >= 5 && c <= 8) ? o[c-5] : 32'h0;
            checks++;
            if (obs_d[c] !== ed) begin
                failures++;
                $display("FAIL ign_other cyc=%0d got=%h exp=%h", c, obs_d[c], ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_alignment();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_ignored_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_responder.md
Name: mm_responder

Overview:
- Main-memory side of the cache-miss interface: the responder to the cache controller's Access_MM request.
- Accepts one block request (refill read or write-back), waits a fixed access latency, then transfers one block as WORDS_PER_BLOCK word beats, one beat per cycle.
- Pulses MM_Done when the block is finished.
- Holds the backing word array; sits between the data cache and the memory model in the MIPS memory subsystem.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word/beat width
WORDS_PER_BLOCK, 4, beats per block; power of two, >=1
DEPTH_WORDS, 1024, word capacity of array; power of two
LATENCY, 4, wait cycles before first beat; >=1

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
Access_MM  in  1  request level from cache controller; sampled only in IDLE
MM_Write  in  1  1 = write-back block, 0 = refill read; sampled with request
MM_Addr  in  ADDR_W  byte address of any byte in target block; sampled with request
MM_WData  in  DATA_W  write beat data, consumed each cycle MM_WReady=1
MM_RData  out  DATA_W  read beat data, valid when MM_RValid=1
MM_RValid  out  1  read beat valid
MM_WReady  out  1  write beat consumed this cycle
MM_Busy  out  1  transaction in progress (WAIT, XFER or DONE)
MM_Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (RESET=1 at rising edge):
  - state <= IDLE; wait counter and beat counter <= 0.
  - All outputs 0 from the next cycle. MM_RData = 0 whenever MM_RValid = 0.
  - Memory array is NOT cleared by reset.
  - Reset mid-transaction aborts it immediately. No Done is issued. Beats already written remain in memory.
- Address mapping:
  - word index = MM_Addr[ADDR_W-1:2] mod DEPTH_WORDS.
  - base = word index with low log2(WORDS_PER_BLOCK) bits cleared (block aligned).
  - Beat k addresses word (base+k) mod DEPTH_WORDS. Wrap-around past the top of the array is silent.
- FSM: IDLE, WAIT, XFER, DONE. Outputs are Moore decodes of registered state and counters.
- IDLE:
  - Busy = 0.
  - If Access_MM = 1 at an edge: latch base and MM_Write; wait counter <= LATENCY-1; go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - Busy = 1; lasts exactly LATENCY cycles.
  - If counter = 0: beat <= 0 and go to XFER. Otherwise decrement the counter.
  - Changes on Access_MM, MM_Addr or MM_Write are ignored.
- XFER:
  - Busy = 1; lasts exactly WORDS_PER_BLOCK cycles, beat = 0 .. WORDS_PER_BLOCK-1.
  - Read: MM_RValid = 1; MM_RData = mem[base+beat] (asynchronous array read).
  - Write: MM_WReady = 1; mem[base+beat] <= MM_WData at the edge ending the cycle. No stall or backpressure; the cache must present beat k in the k-th XFER cycle.
  - At the last beat, go to DONE; otherwise beat increments.
- DONE:
  - Busy = 1, MM_Done = 1 for exactly one cycle; then go to IDLE.
- Latency: request accepted at edge E0.
  - WAIT occupies cycles 1..LATENCY.
  - XFER occupies cycles LATENCY+1 .. LATENCY+WORDS_PER_BLOCK.
  - DONE is cycle LATENCY+WORDS_PER_BLOCK+1.
  - Defaults: WAIT 1-4, beats 5-8, Done in cycle 9.
- Back-to-back: Access_MM still high in the first IDLE cycle after DONE starts a new transaction with the then-current address and MM_Write. The minimum gap between Done and the next WAIT is 1 IDLE cycle. The cache is responsible for dropping Access_MM once its hit resolves.
- Read-after-write: a read of a block issued after a write's Done returns the written data.
- Access_MM glitches outside IDLE have no effect.

Test Plan:
1. Write-back then refill: write block at 0x40 with beats 0x11,0x22,0x33,0x44; then read 0x4C. Expect MM_WReady high in cycles 5-8, Done in cycle 9. Read returns 0x11,0x22,0x33,0x44 with RValid in cycles 5-8 and Done in cycle 9.
2. Alignment: read at byte address 0x4A returns the same block as 0x40. Beat order starts at word 0x10, not at the offset word.
3. Wrap-around: write block at byte 0x1000 (DEPTH_WORDS=1024 → word 0). Read at 0x0000 returns the same data.
4. Back-to-back: hold Access_MM=1 continuously through two reads. Expect Done in cycle 9, IDLE in cycle 10, second Done in cycle 19. Busy is low only in cycle 10.
5. Reset mid-transfer: assert RESET during write beat 2. Expect all outputs 0 the next cycle and no Done. A subsequent read shows beats 0-1 updated and beats 2-3 unchanged.
6. Ignored inputs: change MM_Addr and MM_Write during WAIT. The transfer uses the originally latched base and direction.
